// File: rtl/divider_8bit_seq.sv
// ============================================================================
// Module   : divider_8bit_seq
// Purpose  : Iterative 8-bit restoring divider, one quotient bit per clock,
//            start/done handshake. Define DIVIDER_8BIT_SIGNED_EN for signed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_8bit_seq (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] dividend_i,
    input  logic [7:0] divisor_i,
    output logic [7:0] quotient_o,
    output logic [7:0] remainder_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       div_by_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_STEP = 4'd7;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_rem,   w_rem_nxt;
    logic [7:0] r_q,     w_q_nxt;
    logic [7:0] r_div,   w_div_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [7:0] w_quot_nxt, w_remo_nxt;
    logic       w_dbz_nxt;

    logic [8:0] w_r_shift;
    logic       w_ge;
    logic [7:0] w_rem_step;
    logic [7:0] w_q_step;
    logic [7:0] w_dd_mag, w_ds_mag;
    logic [7:0] w_q_final, w_r_final;

    // 9-bit compare; the subtraction only runs when R' >= D, so the true
    // difference is below D and the low 8 bits of the modulo-256 result suffice.
    assign w_r_shift  = {r_rem, r_q[7]};
    assign w_ge       = w_r_shift[8] | (w_r_shift[7:0] >= r_div);
    assign w_rem_step = w_ge ? (w_r_shift[7:0] - r_div) : w_r_shift[7:0];
    assign w_q_step   = {r_q[6:0], w_ge};

`ifdef DIVIDER_8BIT_SIGNED_EN
    logic r_neg_q, w_neg_q_nxt;
    logic r_neg_r, w_neg_r_nxt;

    assign w_dd_mag  = dividend_i[7] ? (8'd0 - dividend_i) : dividend_i;
    assign w_ds_mag  = divisor_i[7]  ? (8'd0 - divisor_i)  : divisor_i;
    assign w_q_final = r_neg_q ? (8'd0 - w_q_step)   : w_q_step;
    assign w_r_final = r_neg_r ? (8'd0 - w_rem_step) : w_rem_step;

    always_comb begin
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        if ((r_state != S_CALC) && start_i) begin
            w_neg_q_nxt = dividend_i[7] ^ divisor_i[7];
            w_neg_r_nxt = dividend_i[7];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
        end
    end
`else
    assign w_dd_mag  = dividend_i;
    assign w_ds_mag  = divisor_i;
    assign w_q_final = w_q_step;
    assign w_r_final = w_rem_step;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = quotient_o;
        w_remo_nxt  = remainder_o;
        w_dbz_nxt   = div_by_zero_o;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_rem_nxt = 8'd0;
                    w_q_nxt   = w_dd_mag;
                    w_div_nxt = w_ds_mag;
                    w_cnt_nxt = 4'd0;
                    if (divisor_i == 8'd0) begin
                        w_state_nxt = S_DONE;
                        w_quot_nxt  = 8'hFF;
                        w_remo_nxt  = dividend_i;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_CALC;
                        w_dbz_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_rem_nxt = w_rem_step;
                w_q_nxt   = w_q_step;
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = S_DONE;
                    w_quot_nxt  = w_q_final;
                    w_remo_nxt  = w_r_final;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_rem         <= 8'd0;
            r_q           <= 8'd0;
            r_div         <= 8'd0;
            r_cnt         <= 4'd0;
            quotient_o    <= 8'd0;
            remainder_o   <= 8'd0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rem         <= w_rem_nxt;
            r_q           <= w_q_nxt;
            r_div         <= w_div_nxt;
            r_cnt         <= w_cnt_nxt;
            quotient_o    <= w_quot_nxt;
            remainder_o   <= w_remo_nxt;
            busy_o        <= (w_state_nxt == S_CALC);
            done_o        <= (w_state_nxt == S_DONE);
            div_by_zero_o <= w_dbz_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider_8bit_seq.sv
// ============================================================================
// Module   : tb_divider_8bit_seq
// Purpose  : Directed self-checking bench for divider_8bit_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_8bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_checks = 0;
    int n_fail   = 0;

    divider_8bit_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge (cycle k); returns 1 ns after the accepting edge.
    task automatic do_start(input logic [7:0] dd, input logic [7:0] ds);
        start    = 1'b1;
        dividend = dd;
        divisor  = ds;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Checks busy over k+1..k+8 and the result in cycle k+9; ends at that negedge.
    task automatic wait_result(input string tag, input logic [7:0] eq, input logic [7:0] er);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, dbz, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_quot", quotient, 8'd0);
        check("rst_rem", remainder, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", dbz, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 13 / 0 : immediate done, no busy
        do_start(8'd13, 8'd0);
        @(negedge clk);
        check("dz_done", done, 1'b1);
        check("dz_busy", busy, 1'b0);
        check("dz_quot", quotient, 8'hFF);
        check("dz_rem", remainder, 8'd13);
        check("dz_flag", dbz, 1'b1);
        @(negedge clk);
        check("dz_done_pulse", done, 1'b0);
        check("dz_flag_held", dbz, 1'b1);
        check("dz_busy_after", busy, 1'b0);

        // 200 / 7 = 28 r 4 (also clears the divide-by-zero flag)
        do_start(8'hC8, 8'h07);
        check("u200_dbz_cleared", dbz, 1'b0);
        wait_result("u200_7", 8'd28, 8'd4);
        @(negedge clk);
        check("u200_done_pulse", done, 1'b0);
        check("u200_quot_held", quotient, 8'd28);

        // 255/1 then 5/9 back to back
        do_start(8'd255, 8'd1);
        wait_result("u255_1", 8'd255, 8'd0);
        do_start(8'd5, 8'd9);
        wait_result("u5_9", 8'd0, 8'd5);
        @(negedge clk);

        // 100/3 with an ignored re-start at k+4
        do_start(8'd100, 8'd3);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("ign_busy", busy, 1'b1);
            if (i == 4) do_start(8'd50, 8'd5);
        end
        @(negedge clk);
        check("ign_done", done, 1'b1);
        check("ign_quot", quotient, 8'd33);
        check("ign_rem", remainder, 8'd1);
        @(negedge clk);

        // reset mid-calculation
        do_start(8'hC8, 8'h07);
        for (int i = 1; i <= 5; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_quot", quotient, 8'd0);
        check("mrst_rem", remainder, 8'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_dbz", dbz, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mrst_no_done", done, 1'b0);
            check("mrst_no_busy", busy, 1'b0);
        end
        do_start(8'd9, 8'd2);
        wait_result("u9_2", 8'd4, 8'd1);
        @(negedge clk);

`ifdef DIVIDER_8BIT_SIGNED_EN
        do_start(8'h9C, 8'h07);
        wait_result("s_m100_7", 8'hF2, 8'hFE);
        @(negedge clk);
        do_start(8'h80, 8'hFF);
        wait_result("s_m128_m1", 8'h80, 8'h00);
        @(negedge clk);
        do_start(8'h64, 8'hF9);
        wait_result("s_100_m7", 8'hF2, 8'h02);
        @(negedge clk);
`else
        do_start(8'h9C, 8'h07);
        wait_result("u156_7", 8'd22, 8'd2);
        @(negedge clk);
        do_start(8'd128, 8'd255);
        wait_result("u128_255", 8'd0, 8'd128);
        @(negedge clk);
        do_start(8'd255, 8'd16);
        wait_result("u255_16", 8'd15, 8'd15);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
